serial_adder_ctrl: RTL

//  Bit-serial WIDTH-bit adder. It is the sequential stage wrapped around the existing single-bit

---
 rtl/serial_adder_ctrl_pkg.sv | 22 ++
 rtl/serial_adder_ctrl_full_adder.sv | 17 +
 rtl/serial_adder_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and a
// helper for sizing the bit counter.
package serial_adder_ctrl_pkg;

    // Encoding 2'd3 is never entered; the FSM steers it back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_BAD  = 2'd3
    } state_e;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 32;

    // Counter width: max(1, clog2(width)), so WIDTH=1 still has a
    // one-bit counter whose terminal value is 0.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell.
// Ports: A, B, C_in in; Sum, C_out out.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic C_in,
    output logic Sum,
    output logic C_out
);

    logic p;

    assign p     = A ^ B;
    assign Sum   = p ^ C_in;
    assign C_out = (A & B) | (C_in & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder, LSB first, carry in a flop.
// Ports: clk, rst_n, in_valid/in_ready + A, B, C_in in; out_valid/out_ready + Sum, C_out out.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             C_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH-1:0] s_next;

    full_adder u_fa (
        .A     (a_sh_q[0]),
        .B     (b_sh_q[0]),
        .C_in  (carry_q),
        .Sum   (fa_s),
        .C_out (fa_c)
    );

    // New sum bit enters at the MSB end. Built on WIDTH+1 bits so the
    // same expression holds for WIDTH=1.
    assign s_ext  = {fa_s, s_sh_q};
    assign s_next = s_ext[WIDTH:1];

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        s_sh_d    = s_sh_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    carry_d = C_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = s_next;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = s_next;
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // A concurrent in_valid waits for IDLE next cycle.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Results persist until the next RUN->DONE edge.
    assign Sum   = sum_q;
    assign C_out = cout_q;

endmodule
